// File: rtl/button_pkg.sv
// Purpose     : shared types and constants for the push-button conditioner.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: ms-to-cycles helper, per-channel debounce state enum, and the
// default debounce / long-press durations used by button_conditioner.
package button_pkg;

    localparam int BTN_DEBOUNCE_MS_DEFAULT = 10;
    localparam int BTN_HOLD_MS_DEFAULT     = 1000;

    // The debounced level doubles as the FSM state, so the encoding is fixed:
    // IDLE reads as level 0 and PRESSED as level 1.
    typedef enum logic {
        BTN_IDLE    = 1'b0,
        BTN_PRESSED = 1'b1
    } btn_state_e;

    // Whole cycles in `ms` milliseconds at `clk_hz`. The division comes first so
    // that 50 MHz x 1000 ms stays inside a 32-bit int.
    function automatic int btn_ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// Purpose     : one button channel - pin synchroniser, debounce FSM, optional long-press counter.
// Latency     : level and press/release pulse change SYNC_STAGES+DEBOUNCE_CYCLES edges after the pin step.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
//
// Ports: sys_clk_50m / sys_rst_n (synchronous, active-low), button (raw async pin),
//        btn_level (debounced, 1 = pressed), btn_press / btn_release / btn_hold (1-cycle pulses).
// Optional: BUTTON_CONDITIONER_LONG_PRESS_EN adds the hold counter and HOLD_CYCLES parameter;
//           without it btn_hold is tied to 0.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    ,
    parameter int HOLD_CYCLES     = 50_000_000
`endif
) (
    input  logic sys_clk_50m,
    input  logic sys_rst_n,
    input  logic button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level of a button that is not pressed; also the XOR mask that turns
    // the synchronised pin into "1 = pressed".
    localparam logic            RELEASED_PIN = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    btn_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_d, release_d;
    logic                   press_q, release_q;

    // Synchroniser loads the released level in reset so that a button held
    // through reset release is seen as a fresh press.
    always_ff @(posedge sys_clk_50m) begin
        if (!sys_rst_n) begin
            sync_q <= {SYNC_STAGES{RELEASED_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1] ^ RELEASED_PIN;

    // Debounce: count consecutive edges on which the synchronised input
    // disagrees with the current level; any agreement restarts the count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_n == (state_q == BTN_PRESSED)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (sync_n) begin
                state_d = BTN_PRESSED;
                press_d = 1'b1;
            end else begin
                state_d   = BTN_IDLE;
                release_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_50m) begin
        if (!sys_rst_n) begin
            state_q   <= BTN_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = (state_q == BTN_PRESSED);
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              hold_q;

    // Counts edges spent pressed. Saturating at HOLD_MAX gives exactly one
    // pulse per press; a release on the same edge as the threshold wins.
    always_ff @(posedge sys_clk_50m) begin
        if (!sys_rst_n || !btn_level || release_d) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            hold_q     <= (hold_cnt_q == HOLD_PRE);
        end else begin
            hold_q     <= 1'b0;
        end
    end

    assign btn_hold = hold_q;
`else
    assign btn_hold = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Purpose     : board push-button front-end - sync, debounce and edge-detect NUM_BUTTONS pins.
// Latency     : SYNC_STAGES+DEBOUNCE_CYCLES edges from pin step to level change and pulse.
// Backpressure: none; consumers must take the one-cycle pulses when they appear.
//
// Ports: sys_clk_50m (50 MHz), sys_rst_n (synchronous, active-low), buttons (raw pins),
//        btn_level (debounced, 1 = pressed), btn_press / btn_release / btn_hold (1-cycle pulses).
// Optional: define BUTTON_CONDITIONER_LONG_PRESS_EN for the long-press btn_hold pulse.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = BTN_DEBOUNCE_MS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1,
    parameter int HOLD_MS     = BTN_HOLD_MS_DEFAULT
) (
    input  logic                   sys_clk_50m,
    input  logic                   sys_rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_hold
);

    localparam int DEBOUNCE_CYCLES = btn_ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int HOLD_CYCLES     = btn_ms_to_cycles(CLK_HZ, HOLD_MS);
`endif

    // The debounce counter needs at least two states and the synchroniser at
    // least two flops to be meaningful.
    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || HOLD_MS < 0) begin : g_bad_cfg
        $error("button_conditioner: invalid DEBOUNCE/SYNC/HOLD configuration");
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            ,
            .HOLD_CYCLES     (HOLD_CYCLES)
`endif
        ) u_ch (
            .sys_clk_50m (sys_clk_50m),
            .sys_rst_n   (sys_rst_n),
            .button      (buttons[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_hold    (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose     : self-checking bench for button_conditioner (1 kHz clock, 4-cycle debounce, 10-cycle hold).
// Latency     : n/a.
// Backpressure: n/a.
module tb_button_conditioner;

    localparam int NB    = 4;
    localparam int DB    = 4;   // 1000 Hz / 1000 * 4 ms
    localparam int HOLD  = 10;  // 1000 Hz / 1000 * 10 ms
    localparam int RING  = 16;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          sys_clk_50m = 1'b0;
    logic          sys_rst_n;
    logic [NB-1:0] buttons;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;

    button_conditioner #(
        .NUM_BUTTONS (NB),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .SYNC_STAGES (2),
        .ACTIVE_LOW  (1),
        .HOLD_MS     (10)
    ) dut (
        .sys_clk_50m (sys_clk_50m),
        .sys_rst_n   (sys_rst_n),
        .buttons     (buttons),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold)
    );

    always #5 sys_clk_50m = ~sys_clk_50m;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The debouncer sees, at edge x, the pin sampled at edge x-2 (or "released"
    // if reset was active at x-1 or x-2). The level flips at edge e exactly when
    // the last DB seen values all disagree with the level and no reset edge lies
    // in that window.
    logic [NB-1:0] pin_h [RING];
    logic          rst_h [RING];
    int            e = 100;
    int            press_edge [NB];
    logic [NB-1:0] exp_level = '0, exp_press = '0, exp_release = '0, exp_hold = '0;

    initial begin
        for (int i = 0; i < RING; i++) begin
            pin_h[i] = '1;
            rst_h[i] = 1'b1;
        end
        for (int c = 0; c < NB; c++) press_edge[c] = -1000;
    end

    function automatic logic seen(input int x, input int ch);
        if (rst_h[(x-1)%RING] || rst_h[(x-2)%RING]) return 1'b0;
        return ~pin_h[(x-2)%RING][ch];
    endfunction

    always @(posedge sys_clk_50m) begin
        e++;
        pin_h[e%RING] = buttons;
        rst_h[e%RING] = !sys_rst_n;
        exp_press   = '0;
        exp_release = '0;
        exp_hold    = '0;
        if (!sys_rst_n) begin
            exp_level = '0;
            for (int c = 0; c < NB; c++) press_edge[c] = -1000;
        end else begin
            for (int c = 0; c < NB; c++) begin
                logic flip;
                flip = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (rst_h[(e-k)%RING] || seen(e-k, c) == exp_level[c]) flip = 1'b0;
                if (flip) begin
                    exp_level[c] = ~exp_level[c];
                    if (exp_level[c]) begin
                        exp_press[c]  = 1'b1;
                        press_edge[c] = e;
                    end else begin
                        exp_release[c] = 1'b1;
                        press_edge[c]  = -1000;
                    end
                end else if (HOLD_EN && exp_level[c] && (e - press_edge[c]) == HOLD) begin
                    exp_hold[c] = 1'b1;
                end
            end
        end
    end

    // Single compare process, on the falling edge, every cycle.
    always @(negedge sys_clk_50m) begin
        chk("level",   int'(btn_level),   int'(exp_level));
        chk("press",   int'(btn_press),   int'(exp_press));
        chk("release", int'(btn_release), int'(exp_release));
        chk("hold",    int'(btn_hold),    int'(exp_hold));
        chk("press_and_release", int'(btn_press & btn_release), 0);
    end

    // ---------------- directed helpers ----------------
    // Watches n falling edges; index k corresponds to the k-th rising edge after
    // the call, counting the first one as 0.
    task automatic watch(input int ch, input int n,
                         output int np, output int fp, output int nr, output int fr,
                         output int nh, output int fh);
        np = 0; nr = 0; nh = 0; fp = -1; fr = -1; fh = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk_50m);
            if (btn_press[ch])   begin if (fp < 0) fp = k; np++; end
            if (btn_release[ch]) begin if (fr < 0) fr = k; nr++; end
            if (btn_hold[ch])    begin if (fh < 0) fh = k; nh++; end
        end
    endtask

    int np, fp, nr, fr, nh, fh;
    int rst_left;

    initial begin
        sys_rst_n = 1'b0;
        buttons   = 4'b1111;

        // Reset with all buttons released.
        repeat (20) @(negedge sys_clk_50m);
        chk("rst_level",  int'(btn_level), 0);
        chk("rst_pulses", int'(btn_press | btn_release | btn_hold), 0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk_50m);

        // Clean press on channel 0: pulse on the 6th edge (index 5).
        buttons[0] = 1'b0;
        watch(0, 8, np, fp, nr, fr, nh, fh);
        chk("t2_press_cnt",  np, 1);
        chk("t2_press_edge", fp, 5);
        chk("t2_level",      int'(btn_level[0]), 1);

        // 3-cycle glitch on channel 1 is rejected.
        buttons[1] = 1'b0;
        repeat (3) @(negedge sys_clk_50m);
        buttons[1] = 1'b1;
        watch(1, 12, np, fp, nr, fr, nh, fh);
        chk("t3_pulses", np + nr, 0);
        chk("t3_level",  int'(btn_level[1]), 0);

        // Bounce 0,1,0,0,... on channel 2: single press 5 edges after final 1->0.
        buttons[2] = 1'b0;
        @(negedge sys_clk_50m);
        buttons[2] = 1'b1;
        @(negedge sys_clk_50m);
        buttons[2] = 1'b0;
        watch(2, 12, np, fp, nr, fr, nh, fh);
        chk("t4_press_cnt",  np, 1);
        chk("t4_press_edge", fp, 5);

        // Press, hold, release on channel 3.
        buttons[3] = 1'b0;
        watch(3, 24, np, fp, nr, fr, nh, fh);
        chk("t5_press_edge", fp, 5);
        chk("t5_hold_cnt",   nh, HOLD_EN ? 1 : 0);
        chk("t5_hold_edge",  fh, HOLD_EN ? 5 + HOLD : -1);
        buttons[3] = 1'b1;
        watch(3, 10, np, fp, nr, fr, nh, fh);
        chk("t5_release_cnt",  nr, 1);
        chk("t5_release_edge", fr, 5);
        chk("t5_level",        int'(btn_level[3]), 0);

        // Reset two counts into a debounce on channel 1, pin kept pressed.
        buttons[1] = 1'b0;
        repeat (4) @(negedge sys_clk_50m);
        sys_rst_n = 1'b0;
        watch(1, 3, np, fp, nr, fr, nh, fh);
        chk("t6_rst_pulses", np + nr + nh, 0);
        chk("t6_rst_level",  int'(btn_level), 0);
        sys_rst_n = 1'b1;
        watch(1, 10, np, fp, nr, fr, nh, fh);
        chk("t6_press_cnt",  np, 1);
        chk("t6_press_edge", fp, 5);

        // Random pin activity with occasional short resets.
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk_50m);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) sys_rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                sys_rst_n = 1'b0;
                rst_left  = $urandom_range(1, 3);
            end
            for (int ch = 0; ch < NB; ch++)
                if ($urandom_range(0, 99) < 8) buttons[ch] = ~buttons[ch];
        end
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk_50m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
